// File: rtl/fbr_pkg.sv
// Shared types and line-level constants for the feedback-register serial transmitter.
package fbr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic SER_IDLE  = 1'b1;
  localparam logic SER_START = 1'b0;

endpackage

// File: rtl/fbr_bit_timer.sv
// Per-bit timer: counts 0..BIT_CYCLES-1 while run is high and pulses tick on terminal count.
module fbr_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int TW = $clog2(BIT_CYCLES + 1);
  localparam logic [TW-1:0] TERM = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // With BIT_CYCLES=1 the counter is pinned at zero and tick simply follows run.
  always_comb begin
    tick  = run && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (!run || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fbr_serial_tx.sv
// Frames a parallel word as start/data(LSB first)/[parity]/stop on one serial line.
// Define FBR_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fbr_serial_tx
  import fbr_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
  logic [WIDTH-1:0] shreg_shifted;
`ifdef FBR_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  fbr_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .run  (state_q != IDLE),
    .tick (tick)
  );

  assign shreg_shifted = shreg_q >> 1;

  // ser_d always carries the value of the bit being entered, so the line is registered.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ser_d     = ser_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef FBR_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        ser_d = SER_IDLE;
        if (din_valid) begin
          shreg_d   = din;
`ifdef FBR_TX_PARITY_EN
          par_d     = ^din;
`endif
          bit_cnt_d = '0;
          ser_d     = SER_START;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          ser_d     = shreg_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_shifted;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef FBR_TX_PARITY_EN
            ser_d   = par_q;
            state_d = PARITY;
`else
            ser_d   = SER_IDLE;
            state_d = STOP;
`endif
          end else begin
            ser_d     = shreg_shifted[0];
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
`ifdef FBR_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          ser_d   = SER_IDLE;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          ser_d   = SER_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ser_d   = SER_IDLE;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ser_q     <= SER_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Datapath registers carry no reset; their contents are only read after an accept.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef FBR_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign din_ready = (state_q == IDLE);
  assign ser_out   = ser_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fbr_serial_tx.sv
// Bench for fbr_serial_tx: directed and random frames on a BIT_CYCLES=2 and a BIT_CYCLES=1 instance.
module tb_fbr_serial_tx;

  localparam int W = 4;
`ifdef FBR_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] din, din1;
  logic din_valid, din_valid1;
  logic din_ready, ser_out, busy, done;
  logic din_ready1, ser_out1, busy1, done1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fbr_serial_tx #(.WIDTH(W), .BIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .busy(busy), .done(done)
  );

  fbr_serial_tx #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .ser_out(ser_out1), .busy(busy1), .done(done1)
  );

  // Frame as a list of bit slots: start, data LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [W-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= W) return w[idx-1];
    if (P == 1 && idx == W + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample n is taken just after the n-th edge following the accept edge.
  task automatic frame(input logic [W-1:0] w, input bit hold, input logic [W-1:0] w2,
                       input string tag);
    int len;
    len = (W + 2 + P) * 2;
    din = w;
    din_valid = 1'b1;
    step();
    if (!hold) din_valid = 1'b0;
    for (int n = 0; n <= len; n++) begin
      if (n < len) begin
        chk({tag, "_ser"},   ser_out,   exp_bit(w, n / 2));
        chk({tag, "_busy"},  busy,      1'b1);
        chk({tag, "_done"},  done,      1'b0);
        chk({tag, "_ready"}, din_ready, 1'b0);
      end else begin
        chk({tag, "_end_ser"},   ser_out,   1'b1);
        chk({tag, "_end_busy"},  busy,      1'b0);
        chk({tag, "_end_done"},  done,      1'b1);
        chk({tag, "_end_ready"}, din_ready, 1'b1);
      end
      if (hold && n == 2) din = w2;
      if (n < len) step();
    end
  endtask

  task automatic frame1(input logic [W-1:0] w, input bit hold, input logic [W-1:0] w2,
                        input string tag);
    int len;
    len = W + 2 + P;
    din1 = w;
    din_valid1 = 1'b1;
    step();
    if (!hold) din_valid1 = 1'b0;
    for (int n = 0; n <= len; n++) begin
      if (n < len) begin
        chk({tag, "_ser"},  ser_out1,   exp_bit(w, n));
        chk({tag, "_busy"}, busy1,      1'b1);
        chk({tag, "_done"}, done1,      1'b0);
      end else begin
        chk({tag, "_gap_ser"},   ser_out1,   1'b1);
        chk({tag, "_gap_done"},  done1,      1'b1);
        chk({tag, "_gap_ready"}, din_ready1, 1'b1);
      end
      if (hold && n == 1) din1 = w2;
      if (n < len) step();
    end
  endtask

  initial begin
    logic [W-1:0] w;
    reset = 1'b1;
    din = '0; din1 = '0;
    din_valid = 1'b0; din_valid1 = 1'b0;

    // Reset, with a valid word present to show reset wins over accept.
    step();
    din_valid = 1'b1; din = 4'b1111;
    step();
    chk("rst_ser",   ser_out,   1'b1);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_done",  done,      1'b0);
    chk("rst_ready", din_ready, 1'b1);
    chk("rst_ser1",  ser_out1,  1'b1);
    din_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_ser",  ser_out,   1'b1);
    chk("idle_busy", busy,      1'b0);

    frame(4'b1010, 1'b0, '0, "f1010");
    step();
    chk("post_done_clear", done, 1'b0);

    // Held valid with din changing mid-frame; second word follows after one idle cycle.
    frame(4'b0011, 1'b1, 4'b0101, "hold_a");
    frame(4'b0101, 1'b0, '0, "hold_b");
    step();

    // Reset during clock 5 of a frame.
    din = 4'b1111; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int n = 0; n < 4; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ser",   ser_out,   1'b1);
    chk("abort_busy",  busy,      1'b0);
    chk("abort_done",  done,      1'b0);
    chk("abort_ready", din_ready, 1'b1);
    frame(4'b1001, 1'b0, '0, "after_abort");
    step();

    // Parity-relevant pair.
    frame(4'b1010, 1'b0, '0, "p1010");
    step();
    frame(4'b1011, 1'b0, '0, "p1011");
    step();

    // Randomized words with random idle gaps.
    for (int i = 0; i < 16; i++) begin
      w = W'($urandom_range(0, 15));
      frame(w, 1'b0, '0, "rand");
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step();
        chk("rand_idle_ser", ser_out, 1'b1);
      end
    end

    // BIT_CYCLES=1 back-to-back frames.
    frame1(4'b1111, 1'b1, 4'b0000, "bc1_a");
    frame1(4'b0000, 1'b0, '0, "bc1_b");
    step();
    chk("bc1_done_clear", done1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      w = W'($urandom_range(0, 15));
      frame1(w, 1'b0, '0, "bc1_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
